// File: rtl/modbus_pkg.sv
// Shared definitions for the Modbus RTU master request engine.
//   state_e   : request FSM state encoding
//   CRC_INIT  : Modbus CRC-16 seed
//   CRC_POLY  : reflected CRC-16 polynomial
//   bit_cyc   : clocks per UART bit
//   t35_cyc   : clocks in a 3.5-character (10-bit chars) inter-frame gap
//   crc_step  : one LSB-first CRC bit update
package modbus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CRC,
      ST_GAP,
      ST_SEND,
      ST_DRAIN,
      ST_WAIT,
      ST_DONE
   } state_e;

   localparam logic [15:0] CRC_INIT = 16'hFFFF;
   localparam logic [15:0] CRC_POLY = 16'hA001;

   function automatic int unsigned bit_cyc(input int unsigned clk_freq,
                                           input int unsigned baud);
      return clk_freq / baud;
   endfunction

   function automatic int unsigned t35_cyc(input int unsigned clk_freq,
                                           input int unsigned baud);
      return bit_cyc(clk_freq, baud) * 35;
   endfunction

   // Reflected CRC: the incoming bit meets the register LSB.
   function automatic logic [15:0] crc_step(input logic [15:0] crc,
                                            input logic        din);
      logic [15:0] sh;
      sh = {1'b0, crc[15:1]};
      return (crc[0] ^ din) ? (sh ^ CRC_POLY) : sh;
   endfunction

endpackage

// File: rtl/modbus_crc_serial.sv
// Bit-serial Modbus CRC-16, one bit per clock, LSB first.
//   clk_in, rst_in : clock, synchronous active-high reset
//   clear_i        : load CRC_INIT (start of a new frame)
//   start_i        : begin an 8-cycle pass over byte_i (bit 0 consumed this cycle)
//   byte_i         : byte to fold in, sampled with start_i
//   busy_o         : a byte pass is in progress
//   done_o         : high in the cycle the 8th bit is consumed
//   crc_o          : running CRC; final one cycle after done_o
module modbus_crc_serial
   import modbus_pkg::*;
(
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        clear_i,
   input  logic        start_i,
   input  logic [7:0]  byte_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [15:0] crc_o
);

   logic [15:0] crc_q, crc_d;
   logic [6:0]  sh_q, sh_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        run_q, run_d;

   always_comb begin
      crc_d = crc_q;
      sh_d  = sh_q;
      cnt_d = cnt_q;
      run_d = run_q;
      if (clear_i) begin
         crc_d = CRC_INIT;
         run_d = 1'b0;
      end else if (start_i) begin
         crc_d = crc_step(crc_q, byte_i[0]);
         sh_d  = byte_i[7:1];
         cnt_d = 3'd1;
         run_d = 1'b1;
      end else if (run_q) begin
         crc_d = crc_step(crc_q, sh_q[0]);
         sh_d  = {1'b0, sh_q[6:1]};
         if (cnt_q == 3'd7) run_d = 1'b0;
         else               cnt_d = cnt_q + 3'd1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         crc_q <= '0;
         sh_q  <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         crc_q <= crc_d;
         sh_q  <= sh_d;
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end

   assign busy_o = run_q;
   assign done_o = run_q && (cnt_q == 3'd7);
   assign crc_o  = crc_q;

endmodule

// File: rtl/modbus_master_req.sv
// Modbus RTU master request engine: latches one 6-byte request header,
// appends the CRC-16, sends the 8-byte frame through an external UART byte
// transmitter with the 3.5-char inter-frame gap, then waits for a reply
// frame or a timeout.
//   clk_in, rst_in          : clock, synchronous active-high reset
//   req_valid / req_ready   : request handshake (ready only in IDLE)
//   slave_addr, func_code,
//   reg_addr, reg_data      : request fields, sampled on accept only
//   uart_tx_start/data/done : byte interface to uart_byte_tx
//   rx_new_frame            : reply frame complete (receive path)
//   rs485_tx_en             : RS-485 driver enable
//   busy                    : not IDLE
//   crc_out                 : CRC of the latched frame
//   req_done, resp_timeout  : end-of-transaction pulses
module modbus_master_req
   import modbus_pkg::*;
#(
   parameter int unsigned CLK_FREQ         = 50000000,
   parameter int unsigned BAUD_RATE        = 115200,
   parameter int unsigned RESP_TIMEOUT_CYC = 500000
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [7:0]  slave_addr,
   input  logic [7:0]  func_code,
   input  logic [15:0] reg_addr,
   input  logic [15:0] reg_data,
   output logic        uart_tx_start,
   output logic [7:0]  uart_tx_data,
   input  logic        uart_tx_done,
   input  logic        rx_new_frame,
   output logic        rs485_tx_en,
   output logic        busy,
   output logic [15:0] crc_out,
   output logic        req_done,
   output logic        resp_timeout
);

   localparam int unsigned BIT_CYC = bit_cyc(CLK_FREQ, BAUD_RATE);
   localparam int unsigned T35_CYC = t35_cyc(CLK_FREQ, BAUD_RATE);

   state_e          state_q, state_d;
   logic [2:0]      idx_q, idx_d;     // CRC: bytes started; SEND: byte index
   logic            pend_q, pend_d;   // SEND: byte handed to UART, awaiting done
   logic [31:0]     cnt_q, cnt_d;     // DRAIN / WAIT counter
   logic [31:0]     gap_q, gap_d;     // idle clocks since last bus activity
   logic [5:0][7:0] hdr_q, hdr_d;
   logic            bcast_q, bcast_d;
   logic            to_q, to_d;

   logic            crc_clear, crc_start, crc_busy, crc_done;
   logic [15:0]     crc;
   logic [7:0][7:0] frame;

   // CRC bytes go out low byte first.
   assign frame = {crc[15:8], crc[7:0], hdr_q};

   modbus_crc_serial u_crc (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .clear_i (crc_clear),
      .start_i (crc_start),
      .byte_i  (frame[idx_q]),
      .busy_o  (crc_busy),
      .done_o  (crc_done),
      .crc_o   (crc)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      pend_d    = pend_q;
      cnt_d     = cnt_q;
      hdr_d     = hdr_q;
      bcast_d   = bcast_q;
      to_d      = to_q;
      crc_clear = 1'b0;
      crc_start = 1'b0;
      gap_d     = (gap_q < T35_CYC) ? gap_q + 32'd1 : gap_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               hdr_d     = {reg_data[7:0], reg_data[15:8],
                            reg_addr[7:0], reg_addr[15:8],
                            func_code, slave_addr};
               bcast_d   = (slave_addr == 8'h00);
               to_d      = 1'b0;
               idx_d     = '0;
               crc_clear = 1'b1;
               state_d   = ST_CRC;
            end
         end
         ST_CRC: begin
            // The CRC pass does not count toward the gap, so a request
            // arriving right after a transaction still sees a full 3.5-char
            // silence after its 49 setup cycles.
            gap_d = gap_q;
            if (!crc_busy && idx_q < 3'd6) begin
               crc_start = 1'b1;
               idx_d     = idx_q + 3'd1;
            end
            if (crc_done && idx_q == 3'd6) begin
               idx_d   = '0;
               pend_d  = 1'b0;
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            if (gap_q >= T35_CYC) state_d = ST_SEND;
         end
         ST_SEND: begin
            if (!pend_q) begin
               pend_d = 1'b1;
            end else if (uart_tx_done) begin
               pend_d = 1'b0;
               if (idx_q == 3'd7) begin
                  cnt_d   = '0;
                  state_d = ST_DRAIN;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         ST_DRAIN: begin
            // Keep the driver on for one bit time so the stop bit of the
            // last byte leaves the transceiver intact.
            if (cnt_q >= BIT_CYC - 1) begin
               cnt_d   = '0;
               state_d = bcast_q ? ST_DONE : ST_WAIT;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         ST_WAIT: begin
            // Reply is checked first so it wins a tie with expiry.
            if (rx_new_frame) begin
               state_d = ST_DONE;
            end else if (cnt_q >= RESP_TIMEOUT_CYC - 1) begin
               to_d    = 1'b1;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (rx_new_frame || state_q == ST_DONE) gap_d = '0;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         pend_q  <= 1'b0;
         cnt_q   <= '0;
         // Nothing is in flight after reset, so the bus counts as idle.
         gap_q   <= T35_CYC;
         hdr_q   <= '0;
         bcast_q <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         hdr_q   <= hdr_d;
         bcast_q <= bcast_d;
         to_q    <= to_d;
      end
   end

   assign req_ready     = (state_q == ST_IDLE);
   assign busy          = (state_q != ST_IDLE);
   assign uart_tx_start = (state_q == ST_SEND) && !pend_q;
   assign uart_tx_data  = (state_q == ST_SEND) ? frame[idx_q] : 8'h00;
   // Reset releases the bus immediately rather than at the next edge.
   assign rs485_tx_en   = ((state_q == ST_SEND) || (state_q == ST_DRAIN)) && !rst_in;
   assign crc_out       = crc;
   assign req_done      = (state_q == ST_DONE);
   assign resp_timeout  = (state_q == ST_DONE) && to_q;

endmodule
